// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, FSM states and default width.
// The opcode legality helper is only used when ALU_ARB_OPCHECK_EN is defined.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SLL = 4'b0011;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      AND, OR, ADD, SLL, SUB, SLT, NOR: ctrl_legal = 1'b1;
      default:                          ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin grant: on contention the port that did not win last time is chosen.
// Purely combinational; the caller owns the last-grant register.
module alu_rr_arbiter (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant_vld,
  output logic       o_grant
);

  always_comb begin
    o_grant_vld = |i_valid;
    o_grant     = 1'b0;
    if (&i_valid) begin
      o_grant = ~i_last_grant;
    end else if (i_valid[1]) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional macro ALU_ARB_OPCHECK_EN adds illegal-opcode rejection and respN_err outputs.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  input  logic [4:0]       req1_shamt,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_OPCHECK_EN
  ,
  output logic             resp0_err,
  output logic             resp1_err
`endif
);

  localparam int CNT_W = 4;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("alu_arbiter: LATENCY must be in 1..15");
    end
  endgenerate

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic                   r_last_grant;
  logic [CNT_W-1:0]       r_count;
  logic [WIDTH-1:0]       r_alu_a;
  logic [WIDTH-1:0]       r_alu_b;
  logic [3:0]             r_alu_ctrl;
  logic [4:0]             r_alu_shamt;
  logic [1:0]             r_resp_valid;
  logic [1:0][WIDTH-1:0]  r_resp_result;
  logic [1:0]             r_resp_zero;
`ifdef ALU_ARB_OPCHECK_EN
  logic [1:0]             r_resp_err;
`endif

  logic                   w_grant_vld;
  logic                   w_grant;
  logic                   w_accept;
  logic                   w_sample;
  logic                   w_release;
  logic                   w_resp_rdy;
  logic                   w_illegal;
  logic [WIDTH-1:0]       w_sel_a;
  logic [WIDTH-1:0]       w_sel_b;
  logic [3:0]             w_sel_ctrl;
  logic [4:0]             w_sel_shamt;

  alu_rr_arbiter u_rr (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant_vld  (w_grant_vld),
    .o_grant      (w_grant)
  );

  assign w_sel_a     = w_grant ? req1_a     : req0_a;
  assign w_sel_b     = w_grant ? req1_b     : req0_b;
  assign w_sel_ctrl  = w_grant ? req1_ctrl  : req0_ctrl;
  assign w_sel_shamt = w_grant ? req1_shamt : req0_shamt;

  // r_last_grant doubles as the index of the port currently being served.
  assign w_resp_rdy = r_last_grant ? resp1_ready : resp0_ready;

`ifdef ALU_ARB_OPCHECK_EN
  assign w_illegal = ~ctrl_legal(w_sel_ctrl);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is gated by reset_n so nothing looks accepted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld && reset_n) begin
          w_accept    = 1'b1;
          w_state_nxt = w_illegal ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_count == '0) begin
          w_sample    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_resp_rdy) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant  <= 1'b1;
      r_count       <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctrl    <= '0;
      r_alu_shamt   <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      r_resp_err    <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
        if (w_illegal) begin
          r_resp_valid[w_grant]  <= 1'b1;
          r_resp_result[w_grant] <= '0;
          r_resp_zero[w_grant]   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
          r_resp_err[w_grant]    <= 1'b1;
`endif
        end else begin
          r_alu_a     <= w_sel_a;
          r_alu_b     <= w_sel_b;
          r_alu_ctrl  <= w_sel_ctrl;
          r_alu_shamt <= w_sel_shamt;
          r_count     <= CNT_W'(LATENCY - 1);
        end
      end
      if (r_state == ST_EXEC && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
      if (w_sample) begin
        r_resp_valid[r_last_grant]  <= 1'b1;
        r_resp_result[r_last_grant] <= alu_result;
        r_resp_zero[r_last_grant]   <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
        r_resp_err[r_last_grant]    <= 1'b0;
`endif
      end
      if (w_release) begin
        r_resp_valid[r_last_grant] <= 1'b0;
      end
    end
  end

  assign req0_ready   = w_accept & ~w_grant;
  assign req1_ready   = w_accept & w_grant;
  assign resp0_valid  = r_resp_valid[0];
  assign resp1_valid  = r_resp_valid[1];
  assign resp0_result = r_resp_result[0];
  assign resp1_result = r_resp_result[1];
  assign resp0_zero   = r_resp_zero[0];
  assign resp1_zero   = r_resp_zero[1];
`ifdef ALU_ARB_OPCHECK_EN
  assign resp0_err    = r_resp_err[0];
  assign resp1_err    = r_resp_err[1];
`endif
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_control  = r_alu_ctrl;
  assign alu_shamt    = r_alu_shamt;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* interface.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int LAT = 2;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [4:0]   req0_shamt, req1_shamt;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready, resp1_ready;
  logic [W-1:0] resp0_result, resp1_result;
  logic         resp0_zero, resp1_zero;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_control;
  logic [4:0]   alu_shamt;
  logic         alu_zero;
  logic         busy;
`ifdef ALU_ARB_OPCHECK_EN
  logic         resp0_err, resp1_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.LATENCY(LAT), .WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ctrl    (req0_ctrl),
    .req0_shamt   (req0_shamt),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ctrl    (req1_ctrl),
    .req1_shamt   (req1_shamt),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_zero   (resp0_zero),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_zero   (resp1_zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .busy         (busy)
`ifdef ALU_ARB_OPCHECK_EN
    ,
    .resp0_err    (resp0_err),
    .resp1_err    (resp1_err)
`endif
  );

  // Behavioural ALU standing in for the shared datapath ALU.
  logic [W-1:0] m_res;
  always_comb begin
    m_res = '0;
    case (alu_control)
      4'b0000: m_res = alu_a & alu_b;
      4'b0001: m_res = alu_a | alu_b;
      4'b0010: m_res = alu_a + alu_b;
      4'b0011: m_res = alu_b << alu_shamt;
      4'b0110: m_res = alu_a - alu_b;
      4'b0111: m_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: m_res = ~(alu_a | alu_b);
      default: m_res = '0;
    endcase
  end
  assign alu_result = m_res;
  assign alu_zero   = (m_res == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Issue one op on a single port, check latency/result, then consume the response.
  task automatic run_op(input int port, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_zero, input string tag);
    int k;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_shamt = sh;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_shamt = sh;
    end
    #1;
    chk1({tag, ".rdy"},       (port == 0) ? req0_ready : req1_ready, 1'b1);
    chk1({tag, ".rdy_other"}, (port == 0) ? req1_ready : req0_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hdead_beef; req0_b = 32'h1234_5678; req0_shamt = 5'd31;
    req1_a = 32'hcafe_f00d; req1_b = 32'h8765_4321; req1_shamt = 5'd30;
    chk1({tag, ".busy"}, busy, 1'b1);
    k = 0;
    while (!((port == 0) ? resp0_valid : resp1_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
      chk({tag, ".alu_shamt"}, {27'd0, alu_shamt}, {27'd0, sh});
      chk({tag, ".alu_ctrl"},  {28'd0, alu_control}, {28'd0, ctrl});
    end
    chk({tag, ".latency"}, k, LAT);
    chk({tag, ".result"}, (port == 0) ? resp0_result : resp1_result, exp_res);
    chk1({tag, ".zero"}, (port == 0) ? resp0_zero : resp1_zero, exp_zero);
    chk1({tag, ".other_valid"}, (port == 0) ? resp1_valid : resp0_valid, 1'b0);
    if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk1({tag, ".valid_clr"}, (port == 0) ? resp0_valid : resp1_valid, 1'b0);
    chk1({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[$];
    int acc_port[$];
    int nresp;
    int k;

    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_shamt = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_shamt = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.req0_ready", req0_ready, 1'b0);
    chk1("rst.resp0_valid", resp0_valid, 1'b0);
    chk1("rst.resp1_valid", resp1_valid, 1'b0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.resp0_result", resp0_result, 32'd0);
    @(posedge clk); #1;
    chk1("rst.busy_hold", busy, 1'b0);
    req0_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD on port 0
    run_op(0, ADD, 32'd4, 32'd1, 5'd0, 32'd5, 1'b0, "t1.add");

    // SLL on port 0 with increasing shift amounts
    run_op(0, SLL, 32'd0, 32'd1, 5'd3, 32'd8,  1'b0, "t3.sll3");
    run_op(0, SLL, 32'd0, 32'd1, 5'd4, 32'd16, 1'b0, "t3.sll4");
    run_op(0, SLL, 32'd0, 32'd1, 5'd5, 32'd32, 1'b0, "t3.sll5");

    // SUB and SLT on port 1 (leaves last grant on port 1)
    run_op(1, SUB, 32'd4, 32'd4, 5'd0, 32'd0, 1'b1, "t2.sub");
    run_op(1, SLT, 32'd1, 32'd4, 5'd0, 32'd1, 1'b0, "t2.slt");

    // Sustained contention with both response channels always ready
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd1; req0_ctrl = ADD; req0_shamt = '0;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd1; req1_ctrl = OR;  req1_shamt = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    nresp = 0;
    for (int c = 0; c < 4 * (LAT + 2); c++) begin
      #1;
      if (req0_ready) begin acc_cyc.push_back(c); acc_port.push_back(0); end
      if (req1_ready) begin acc_cyc.push_back(c); acc_port.push_back(1); end
      if (resp0_valid) begin
        chk($sformatf("t4.res0_c%0d", c), resp0_result, 32'd5);
        chk1($sformatf("t4.excl0_c%0d", c), resp1_valid, 1'b0);
        nresp++;
      end
      if (resp1_valid) begin
        chk($sformatf("t4.res1_c%0d", c), resp1_result, 32'd5);
        chk1($sformatf("t4.excl1_c%0d", c), resp0_valid, 1'b0);
        nresp++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk("t4.accepts", acc_port.size(), 4);
    chk("t4.responses", nresp, 4);
    for (int i = 0; i < acc_port.size() && i < 4; i++) begin
      chk($sformatf("t4.grant%0d", i), acc_port[i], i % 2);
      if (i > 0) chk($sformatf("t4.spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], LAT + 2);
    end

    // Response back-pressure on port 0 while port 1 waits
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd1; req0_ctrl = ADD; req0_shamt = '0;
    resp1_ready = 1'b1;
    #1;
    chk1("t5.rdy", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_ctrl = SUB;
    k = 0;
    while (!resp0_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5.latency", k, LAT);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("t5.hold_valid%0d", i), resp0_valid, 1'b1);
      chk($sformatf("t5.hold_result%0d", i), resp0_result, 32'd5);
      chk1($sformatf("t5.no_accept%0d", i), req1_ready, 1'b0);
      chk1($sformatf("t5.no_resp1_%0d", i), resp1_valid, 1'b0);
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    chk1("t5.valid_clr", resp0_valid, 1'b0);
    chk1("t5.idle", busy, 1'b0);
    chk1("t5.req1_rdy_idle", req1_ready, 1'b1);
    req1_valid = 1'b0; resp1_ready = 1'b0;
    @(posedge clk); #1;
    chk1("t5.withdraw_idle", busy, 1'b0);
    chk1("t5.withdraw_resp1", resp1_valid, 1'b0);

    // Reset during EXEC discards the op
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_ctrl = SUB; req1_shamt = 5'd7;
    #1;
    chk1("t6.rdy", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk1("t6.busy", busy, 1'b1);
    chk("t6.alu_ctrl", {28'd0, alu_control}, 32'd6);
    reset_n = 1'b0;
    #1;
    chk1("t6.rst_busy", busy, 1'b0);
    chk("t6.rst_alu_a", alu_a, 32'd0);
    chk("t6.rst_alu_b", alu_b, 32'd0);
    chk("t6.rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
    chk("t6.rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
    chk1("t6.rst_resp1", resp1_valid, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("t6.stale0_%0d", i), resp0_valid, 1'b0);
      chk1($sformatf("t6.stale1_%0d", i), resp1_valid, 1'b0);
      chk1($sformatf("t6.idle_%0d", i), busy, 1'b0);
    end
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_ctrl = AND; req1_shamt = '0;
    run_op(0, ADD, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0, "t6.post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
